// File: rtl/mem_access_ctrl.sv
// Arbitrates the single-port unified memory between instruction fetch and data
// loads/stores, with data taking priority, and produces the pipeline stall.
module mem_access_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_fault,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, D_ISSUE, D_WAIT, I_ISSUE, I_WAIT} state_t;

  state_t      r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0] r_if_rdata, w_if_rdata_n;
  logic [31:0] r_d_rdata, w_d_rdata_n;
  logic [31:0] r_mem_addr, w_mem_addr_n;
  logic [31:0] r_mem_wdata, w_mem_wdata_n;
  logic [3:0]  r_mem_we, w_mem_we_n;
  logic        r_if_valid, w_if_valid_n;
  logic        r_d_done, w_d_done_n;
  logic        r_d_fault, w_d_fault_n;
  logic        r_mem_en, w_mem_en_n;

  logic        w_dreq, w_ireq, w_illegal;
  logic [1:0]  w_off;
  logic [3:0]  w_we;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_ok;

  // A request still high during its own completion pulse is the one just served.
  assign w_dreq      = (d_read | d_write) & ~r_d_done;
  assign w_ireq      = if_req & ~r_if_valid;
  assign w_off       = d_addr[1:0];
  assign w_unused_ok = ^if_addr[1:0];

  assign stall     = (d_read | d_write) & ~r_d_done;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_done    = r_d_done;
  assign d_fault   = r_d_fault;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_comb begin
    w_illegal = 1'b0;
    if (d_read && d_write)
      w_illegal = 1'b1;
    else if (d_write && !(d_funct3 inside {3'b000, 3'b001, 3'b010}))
      w_illegal = 1'b1;
    else if (d_read && (d_funct3 inside {3'b011, 3'b110, 3'b111}))
      w_illegal = 1'b1;
    else if (d_funct3[1:0] == 2'b01 && d_addr[0])
      w_illegal = 1'b1;
    else if (d_funct3 == 3'b010 && w_off != 2'b00)
      w_illegal = 1'b1;
  end

  always_comb begin
    w_we    = 4'b1111;
    w_wdata = d_wdata;
    case (d_funct3[1:0])
      2'b00: begin
        w_we    = 4'b0001 << w_off;
        w_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        w_we    = d_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (w_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: ;
    endcase
    w_half = d_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (d_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Next-state logic; mem_en and completion pulses default low so each lasts one cycle.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_if_rdata_n  = r_if_rdata;
    w_d_rdata_n   = r_d_rdata;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_we_n    = 4'b0000;
    w_mem_en_n    = 1'b0;
    w_if_valid_n  = 1'b0;
    w_d_done_n    = 1'b0;
    w_d_fault_n   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq) begin
          if (w_illegal) begin
            w_d_done_n  = 1'b1;
            w_d_fault_n = 1'b1;
            w_d_rdata_n = 32'h0;
          end else begin
            w_state_n    = D_ISSUE;
            w_mem_en_n   = 1'b1;
            w_mem_addr_n = {d_addr[31:2], 2'b00};
            if (d_write) begin
              w_mem_we_n    = w_we;
              w_mem_wdata_n = w_wdata;
            end
          end
        end else if (w_ireq) begin
          w_state_n    = I_ISSUE;
          w_mem_en_n   = 1'b1;
          w_mem_addr_n = {if_addr[31:2], 2'b00};
        end
      end
      D_ISSUE: begin
        w_cnt_n = CW'(MEM_LAT);
        if (d_write) begin
          w_d_done_n = 1'b1;
          w_state_n  = IDLE;
        end else begin
          w_state_n = D_WAIT;
        end
      end
      I_ISSUE: begin
        w_cnt_n   = CW'(MEM_LAT);
        w_state_n = I_WAIT;
      end
      D_WAIT: begin
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_d_rdata_n = w_load;
          w_d_done_n  = 1'b1;
          w_state_n   = IDLE;
        end
      end
      I_WAIT: begin
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_if_rdata_n = mem_rdata;
          w_if_valid_n = 1'b1;
          w_state_n    = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_if_rdata  <= 32'h0;
      r_d_rdata   <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_we    <= 4'b0000;
      r_mem_en    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_fault   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_if_rdata  <= w_if_rdata_n;
      r_d_rdata   <= w_d_rdata_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_en    <= w_mem_en_n;
      r_if_valid  <= w_if_valid_n;
      r_d_done    <= w_d_done_n;
      r_d_fault   <= w_d_fault_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at MEM_LAT=1 and one at
// MEM_LAT=3 share the stimulus; each step checks against hand-computed values.
module tb_mem_access_ctrl;

  logic        clk, rst, if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_funct3;

  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_done, d_fault, stall, mem_en;
  logic [3:0]  mem_we;

  logic [31:0] s3_if_rdata, s3_d_rdata, s3_mem_addr, s3_mem_wdata;
  logic        s3_if_valid, s3_d_done, s3_d_fault, s3_stall, s3_mem_en;
  logic [3:0]  s3_mem_we;

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid), .d_read(d_read), .d_write(d_write),
    .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_fault(d_fault), .stall(stall), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .if_rdata(s3_if_rdata), .if_valid(s3_if_valid), .d_read(d_read), .d_write(d_write),
    .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(s3_d_rdata),
    .d_done(s3_d_done), .d_fault(s3_d_fault), .stall(s3_stall), .mem_en(s3_mem_en),
    .mem_we(s3_mem_we), .mem_addr(s3_mem_addr), .mem_wdata(s3_mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    d_read   = rd;
    d_write  = wr;
    d_funct3 = f3;
    d_addr   = addr;
    d_wdata  = wdata;
  endtask

  // Load on the MEM_LAT=1 instance: mem_en in cycle 1, d_done in cycle 3.
  task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expAddr, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
    tick();
    checkOutput({tag, ".mem_en"}, {31'h0, mem_en}, 32'h1);
    checkOutput({tag, ".mem_addr"}, mem_addr, expAddr);
    checkOutput({tag, ".mem_we"}, {28'h0, mem_we}, 32'h0);
    checkOutput({tag, ".stall"}, {31'h0, stall}, 32'h1);
    tick();
    checkOutput({tag, ".mem_en_c2"}, {31'h0, mem_en}, 32'h0);
    checkOutput({tag, ".done_c2"}, {31'h0, d_done}, 32'h0);
    tick();
    checkOutput({tag, ".done_c3"}, {31'h0, d_done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, d_fault}, 32'h0);
    checkOutput({tag, ".rdata"}, d_rdata, expData);
    checkOutput({tag, ".stall_c3"}, {31'h0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput({tag, ".done_c4"}, {31'h0, d_done}, 32'h0);
  endtask

  task automatic storeCheck(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expAddr,
                            input logic [3:0] expWe, input logic [31:0] expWdata);
    applyStimulus(1'b0, 1'b1, f3, addr, wdata);
    tick();
    checkOutput({tag, ".mem_en"}, {31'h0, mem_en}, 32'h1);
    checkOutput({tag, ".mem_we"}, {28'h0, mem_we}, {28'h0, expWe});
    checkOutput({tag, ".mem_wdata"}, mem_wdata, expWdata);
    checkOutput({tag, ".mem_addr"}, mem_addr, expAddr);
    tick();
    checkOutput({tag, ".done_c2"}, {31'h0, d_done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, d_fault}, 32'h0);
    checkOutput({tag, ".mem_en_c2"}, {31'h0, mem_en}, 32'h0);
    checkOutput({tag, ".mem_we_c2"}, {28'h0, mem_we}, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput({tag, ".done_c3"}, {31'h0, d_done}, 32'h0);
    checkOutput({tag, ".mem_en_c3"}, {31'h0, mem_en}, 32'h0);
  endtask

  task automatic faultCheck(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    applyStimulus(rd, wr, f3, addr, 32'h5555_AAAA);
    tick();
    checkOutput({tag, ".done"}, {31'h0, d_done}, 32'h1);
    checkOutput({tag, ".fault"}, {31'h0, d_fault}, 32'h1);
    checkOutput({tag, ".rdata"}, d_rdata, 32'h0);
    checkOutput({tag, ".mem_en"}, {31'h0, mem_en}, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput({tag, ".done_c2"}, {31'h0, d_done}, 32'h0);
    checkOutput({tag, ".mem_en_c2"}, {31'h0, mem_en}, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    tick();
    tick();
    checkOutput("rst.mem_en", {31'h0, mem_en}, 32'h0);
    checkOutput("rst.mem_we", {28'h0, mem_we}, 32'h0);
    checkOutput("rst.mem_addr", mem_addr, 32'h0);
    checkOutput("rst.mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst.d_done", {31'h0, d_done}, 32'h0);
    checkOutput("rst.d_fault", {31'h0, d_fault}, 32'h0);
    checkOutput("rst.if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("rst.d_rdata", d_rdata, 32'h0);
    checkOutput("rst.if_rdata", if_rdata, 32'h0);
    checkOutput("rst.stall", {31'h0, stall}, 32'h0);
    checkOutput("rst.s3_mem_en", {31'h0, s3_mem_en}, 32'h0);
    rst = 1'b0;

    $display("[TB] reset during a load wait");
    mem_rdata = 32'h1111_2222;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tick();
    checkOutput("rstmid.mem_en_c1", {31'h0, mem_en}, 32'h1);
    tick();
    checkOutput("rstmid.mem_en_c2", {31'h0, mem_en}, 32'h0);
    rst = 1'b1;
    tick();
    checkOutput("rstmid.mem_en", {31'h0, mem_en}, 32'h0);
    checkOutput("rstmid.d_done", {31'h0, d_done}, 32'h0);
    checkOutput("rstmid.mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput("rstmid.d_done_after", {31'h0, d_done}, 32'h0);
    checkOutput("rstmid.d_rdata", d_rdata, 32'h0);

    $display("[TB] loads");
    mem_rdata = 32'h80FF_1234;
    loadCheck("LB103",  3'b000, 32'h0000_0103, 32'h0000_0100, 32'hFFFF_FF80);
    loadCheck("LHU102", 3'b101, 32'h0000_0102, 32'h0000_0100, 32'h0000_80FF);
    loadCheck("LH102",  3'b001, 32'h0000_0102, 32'h0000_0100, 32'hFFFF_80FF);
    loadCheck("LBU101", 3'b100, 32'h0000_0101, 32'h0000_0100, 32'h0000_0012);
    loadCheck("LH100",  3'b001, 32'h0000_0100, 32'h0000_0100, 32'h0000_1234);
    loadCheck("LW10C",  3'b010, 32'h0000_010C, 32'h0000_010C, 32'h80FF_1234);

    $display("[TB] stores");
    storeCheck("SB201", 3'b000, 32'h0000_0201, 32'hAABB_CCDD, 32'h0000_0200, 4'b0010, 32'hDDDD_DDDD);
    storeCheck("SH202", 3'b001, 32'h0000_0202, 32'hAABB_CCDD, 32'h0000_0200, 4'b1100, 32'hCCDD_CCDD);
    storeCheck("SH200", 3'b001, 32'h0000_0200, 32'h1234_5678, 32'h0000_0200, 4'b0011, 32'h5678_5678);
    storeCheck("SW204", 3'b010, 32'h0000_0204, 32'hAABB_CCDD, 32'h0000_0204, 4'b1111, 32'hAABB_CCDD);

    $display("[TB] faults");
    faultCheck("LW106",  1'b1, 1'b0, 3'b010, 32'h0000_0106);
    faultCheck("RDWR",   1'b1, 1'b1, 3'b010, 32'h0000_0100);
    faultCheck("SBU",    1'b0, 1'b1, 3'b100, 32'h0000_0100);
    faultCheck("LH101",  1'b1, 1'b0, 3'b001, 32'h0000_0101);
    faultCheck("LF011",  1'b1, 1'b0, 3'b011, 32'h0000_0100);

    $display("[TB] data beats fetch");
    mem_rdata = 32'h1234_5678;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0400;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    tick();
    checkOutput("prio.mem_en_c1", {31'h0, mem_en}, 32'h1);
    checkOutput("prio.mem_addr_c1", mem_addr, 32'h0000_0100);
    checkOutput("prio.stall_c1", {31'h0, stall}, 32'h1);
    tick();
    checkOutput("prio.stall_c2", {31'h0, stall}, 32'h1);
    tick();
    checkOutput("prio.d_done_c3", {31'h0, d_done}, 32'h1);
    checkOutput("prio.d_rdata", d_rdata, 32'h1234_5678);
    checkOutput("prio.if_valid_c3", {31'h0, if_valid}, 32'h0);
    checkOutput("prio.stall_c3", {31'h0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput("prio.mem_en_c4", {31'h0, mem_en}, 32'h1);
    checkOutput("prio.mem_addr_c4", mem_addr, 32'h0000_0400);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    checkOutput("prio.mem_en_c5", {31'h0, mem_en}, 32'h0);
    checkOutput("prio.if_valid_c5", {31'h0, if_valid}, 32'h0);
    tick();
    checkOutput("prio.if_valid_c6", {31'h0, if_valid}, 32'h1);
    checkOutput("prio.if_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 1'b0;
    tick();
    checkOutput("prio.if_valid_c7", {31'h0, if_valid}, 32'h0);
    checkOutput("prio.mem_en_c7", {31'h0, mem_en}, 32'h0);

    $display("[TB] MEM_LAT=3 fetch with a load raised mid-fetch");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    mem_rdata = 32'h1357_9BDF;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0800;
    tick();
    checkOutput("lat3.mem_en_c1", {31'h0, s3_mem_en}, 32'h1);
    checkOutput("lat3.mem_addr_c1", s3_mem_addr, 32'h0000_0800);
    tick();
    checkOutput("lat3.mem_en_c2", {31'h0, s3_mem_en}, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
    tick();
    checkOutput("lat3.if_valid_c3", {31'h0, s3_if_valid}, 32'h0);
    checkOutput("lat3.stall_c3", {31'h0, s3_stall}, 32'h1);
    checkOutput("lat3.mem_en_c3", {31'h0, s3_mem_en}, 32'h0);
    tick();
    checkOutput("lat3.if_valid_c4", {31'h0, s3_if_valid}, 32'h0);
    tick();
    checkOutput("lat3.if_valid_c5", {31'h0, s3_if_valid}, 32'h1);
    checkOutput("lat3.if_rdata", s3_if_rdata, 32'h1357_9BDF);
    checkOutput("lat3.mem_en_c5", {31'h0, s3_mem_en}, 32'h0);
    if_req = 1'b0;
    tick();
    checkOutput("lat3.ld_mem_en", {31'h0, s3_mem_en}, 32'h1);
    checkOutput("lat3.ld_mem_addr", s3_mem_addr, 32'h0000_0104);
    mem_rdata = 32'h2468_ACE0;
    tick();
    tick();
    tick();
    checkOutput("lat3.ld_done_c9", {31'h0, s3_d_done}, 32'h0);
    tick();
    checkOutput("lat3.ld_done_c10", {31'h0, s3_d_done}, 32'h1);
    checkOutput("lat3.ld_rdata", s3_d_rdata, 32'h2468_ACE0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checkOutput("lat3.ld_done_c11", {31'h0, s3_d_done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
